// File: rtl/uart_tx_frame_pkg.sv
// Shared definitions for the uart transmit chain: FSM state encodings and
// serial line levels.
package uart_tx_frame_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Handshake bundle between the upstream pulse controller (master) and the
// frame transmitter (slave).
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 start;
    logic [DATA_BITS-1:0] data_in;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (output start, output data_in, input tx, input busy, input done);
    modport slave  (input start, input data_in, output tx, output busy, output done);
endinterface

// File: rtl/uart_tx_frame_rising_edge_detector.sv
// Registered rising-edge detector; shared with the receiver side of the chain.
module rising_edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);
    logic in_d_q, in_d_d;
    logic armed_q, armed_d;

    always_comb begin
        in_d_d  = in;
        armed_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_d_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            in_d_q  <= in_d_d;
            armed_q <= armed_d;
        end
    end

    // armed_q masks the first edge after reset so a level already high is not seen as a rise
    assign rise = in & ~in_d_q & armed_q;
endmodule

// File: rtl/uart_tx_frame.sv
// Serial frame transmitter: one start bit, DATA_BITS payload bits LSB first,
// STOP_BITS stop bits, launched by a rising edge on start.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input logic           clk,
    input logic           reset,
    uart_tx_frame_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rise;
    logic                 bit_end;

    rising_edge_detector u_start_edge (
        .clk   (clk),
        .reset (reset),
        .in    (bus.start),
        .rise  (rise)
    );

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = LINE_IDLE;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                // a rise coinciding with the done pulse is dropped; a fresh edge is needed
                if (rise && !done_q) begin
                    shreg_d = bus.data_in;
                    state_d = S_START;
                    tx_d    = LINE_START;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        tx_d    = LINE_IDLE;
                        state_d = S_STOP;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                        idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                tx_d = LINE_IDLE;
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial transmitter stage sitting directly downstream of pulse_generator in the uart mark1 chain.
- A multi-cycle trigger pulse from pulse_generator starts exactly one 8N1-style frame carrying the latched parallel byte.
- The frame is shifted out LSB-first on tx, using an internal bit-period counter.
- busy and done give the upstream controller its handshake.

Parameters:
- DATA_BITS, 8, payload bits per frame (legal 5..9).
- CLKS_PER_BIT, 16, clk cycles per serial bit (legal >=2).
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  trigger from pulse_generator; any width >=1 cycle; only its rising edge matters.
- data_in  input  DATA_BITS  byte to send; sampled on the accepted start edge only.
- tx  output  1  serial line; idle high.
- busy  output  1  high from the accepted start edge until the end of the last stop bit.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async, active-high): tx=1, busy=0, done=0, state=IDLE, bit counter=0, bit index=0, start_d=0.
- Edge detect: start_d registers start every cycle; rise = start & ~start_d.
  - A pulse of PULSE_WIDTH cycles therefore yields exactly one frame.
  - start held high indefinitely yields exactly one frame.
- IDLE: tx=1, busy=0. On a clock edge with rise=1:
  - latch data_in into the shift register;
  - state<=START, tx<=0, busy<=1, counter<=0.
  - Latency: tx falls on the same edge that samples the rise (registered output), i.e. one cycle after start goes high.
- START: hold tx=0 for CLKS_PER_BIT cycles. When counter==CLKS_PER_BIT-1: counter<=0, tx<=shreg[0], state<=DATA.
- DATA: each bit lasts CLKS_PER_BIT cycles, LSB first.
  - At each bit end: shift right and increment bit index.
  - After bit DATA_BITS-1: tx<=1, state<=STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end: state<=IDLE, busy<=0, done<=1 for exactly one cycle.
- Frame length: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles, with busy high for exactly that many cycles.
- Rise while busy: ignored, never queued. data_in changes while busy have no effect.
- Rise in the same cycle as done: ignored. A new frame requires a fresh rising edge observed while in IDLE.
- Counters: counter width = clog2(CLKS_PER_BIT); bit index width = clog2(DATA_BITS+1). Counters never wrap past their terminal count.
- Reset mid-frame: tx returns to 1 asynchronously, and the aborted frame is not resumed.
  - After reset release, start already high does not trigger, because start_d is sampled first.
- done is never asserted coincident with busy=1 after the final cycle.

Decomposition:
- Shared include uart_defs.vh holds:
  - state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - line levels LINE_IDLE=1'b1, LINE_START=1'b0.
- One natural sub-module: rising_edge_detector (clk, reset, in, rise). It is reused later by the receiver.
- Baud counting stays inline.

Test Plan:
- CLKS_PER_BIT=4, data_in=8'hA5, start pulse 3 cycles wide:
  - tx bits sampled at mid-bit = 0,1,0,1,0,0,1,0,1,1;
  - busy high 40 cycles;
  - done high exactly 1 cycle at cycle 40 after the rise.
- start held high for 100 cycles with data_in=8'h3C: exactly one frame sent, tx then stays 1, only one done pulse.
- Second start rise at cycle 12 of a frame with data_in=8'hFF: ignored; the first frame completes unchanged, and no second frame follows.
- reset asserted at cycle 20 of a frame: tx=1 and busy=0 immediately, without waiting for clk. After release, no frame starts until a new rise.
- Back-to-back: a rise in the first IDLE cycle after done, with data_in=8'h00: the new frame starts with tx falling on that edge, 8 zero data bits, then stop.
- STOP_BITS=2, data_in=8'h81: stop phase lasts 8 cycles, and done comes at cycle 44.
